// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter owning the select of a shared mux8.
// Registers a one-hot grant plus the matching 3-bit select; a grant stays
// locked while its owner keeps requesting.
// Optional hold-timeout: define MUX8_ARB_TIMEOUT_EN to revoke a grant after
// MAX_HOLD consecutive grant cycles (default build holds grants indefinitely
// and ties timeout low).
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Reject out-of-range hold limits at elaboration.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  state_e           st_q, st_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     owner_oh;
  logic [N-1:0]     cand;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             take;
  logic             drop;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             to_q, to_d;
`endif

  // Candidates for this edge: the current owner never competes against itself.
  always_comb begin
    owner_oh = N'(1) << owner_q;
    cand     = (st_q == GRANT) ? (req & ~owner_oh) : req;
  end

  // Round-robin search: first set candidate starting at ptr, wrapping 7->0.
  always_comb begin : rr_search
    logic [IDX_W-1:0] idx;
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'(ptr_q + IDX_W'(k));
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    take    = 1'b0;
    drop    = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif

    case (st_q)
      IDLE: begin
        take = win_vld;
      end
      GRANT: begin
        if (!req[owner_q]) begin
          // Released: hand over on the same edge, or fall idle.
          take = win_vld;
          drop = !win_vld;
        end
`ifdef MUX8_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          // Held too long: revoke; old owner is excluded via cand.
          to_d  = 1'b1;
          ptr_d = IDX_W'(owner_q + IDX_W'(1));
          take  = win_vld;
          drop  = !win_vld;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        drop = 1'b1;
      end
    endcase

    if (take) begin
      st_d    = GRANT;
      owner_d = win_idx;
      ptr_d   = IDX_W'(win_idx + IDX_W'(1));
      gnt_d   = N'(1) << win_idx;
      busy_d  = 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end else if (drop) begin
      st_d   = IDLE;
      gnt_d  = '0;
      busy_d = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
      hold_d = '0;
`endif
    end
  end

  // State and output registers; sel follows the owner register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  // Hold counter and revocation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign sel  = owner_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam int unsigned MAX_HOLD = 4;
  localparam bit          TO_EN    = 1'b1;
`else
  localparam int unsigned MAX_HOLD = 16;
  localparam bit          TO_EN    = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Model state: owner index (-1 when idle), search start, last select,
  // number of cycles the current grant has been visible, expected pulse.
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_cycles;
  bit m_to;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_sel    = 0;
    m_cycles = 0;
    m_to     = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_owner  = w;
    m_sel    = w;
    m_ptr    = (w + 1) % 8;
    m_cycles = 1;
  endtask

  // One clock edge of the arbitration rules, applied to the sampled requests.
  task automatic model_step(input logic [7:0] r);
    int w;
    logic [7:0] rr;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = rr_first(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else if (r[m_owner]) begin
      if (TO_EN && m_cycles >= int'(MAX_HOLD)) begin
        m_to  = 1'b1;
        m_ptr = (m_owner + 1) % 8;
        rr    = r;
        rr[m_owner] = 1'b0;
        w = rr_first(rr, m_ptr);
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end else begin
        m_cycles++;
      end
    end else begin
      w = rr_first(r, m_ptr);
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    check("gnt", 32'(gnt), 32'(eg));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  // Advance one clock: update the model at the edge, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;

    // Single request from idle, held, then released.
    req = 8'h20;
    cycle();
    check("single_gnt", 32'(gnt), 32'h20);
    check("single_sel", 32'(sel), 32'd5);
    repeat (3) cycle();
    check("single_hold", 32'(gnt), 32'h20);
    req = 8'h00;
    cycle();
    check("single_release", 32'(gnt), 32'h00);

    // Mid-grant asynchronous reset with every requester active.
    req = 8'hFF;
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h00);
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("post_rst_first", 32'(gnt), 32'h01);

    // Rotation: each owner holds two cycles, then drops for one cycle.
    for (int i = 0; i < 40; i++) begin
      r = 8'hFF;
      if (m_owner >= 0 && m_cycles >= 2) r[m_owner] = 1'b0;
      req = r;
      cycle();
    end

    // Wrap-around: 6 owns, releases while 0 requests, then re-raises.
    req = 8'h00;
    cycle();
    req = 8'h40;
    cycle();
    check("wrap_g6", 32'(gnt), 32'h40);
    req = 8'h01;
    cycle();
    check("wrap_g0", 32'(gnt), 32'h01);
    req = 8'h41;
    repeat (2) cycle();
    req = 8'h40;
    cycle();
    check("wrap_back6", 32'(gnt), 32'h40);

    // Lock: owner 3 holds while everyone requests.
    req = 8'h00;
    cycle();
    req = 8'h08;
    cycle();
    check("lock_g3", 32'(gnt), 32'h08);
    req = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!TO_EN) check("lock_hold", 32'(gnt), 32'h08);
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    // Timeout: owner 2 holds with 4 also requesting.
    req = 8'h00;
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h14;
    cycle();
    check("to_g2", 32'(gnt), 32'h04);
    repeat (3) cycle();
    check("to_still_g2", 32'(gnt), 32'h04);
    cycle();
    check("to_handover_gnt", 32'(gnt), 32'h10);
    check("to_handover_sel", 32'(sel), 32'd4);
    check("to_pulse", 32'(timeout), 32'h1);
    cycle();
    check("to_pulse_end", 32'(timeout), 32'h0);
`endif

    // Randomized traffic: requesters mostly hold until done, owners drop at random.
    for (int i = 0; i < 800; i++) begin
      if (i % 200 < 20) begin
        r = 8'($urandom);
      end else begin
        r = req;
        for (int b = 0; b < 8; b++) begin
          if (r[b] && b == m_owner && $urandom_range(0, 3) == 0) r[b] = 1'b0;
          else if (!r[b] && $urandom_range(0, 5) == 0) r[b] = 1'b1;
        end
      end
      req = r;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
